float_uart_tx: RTL and testbench

//  Consumer end of the filter output interface (outSignal/dataReady). Buffers

---
 rtl/float_uart_tx.sv | 211 +++++++++++++++++++++
 tb/tb_float_uart_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_uart_tx.sv
// float_uart_tx: buffers 32-bit float results from the filter output and sends
// each one as four UART 8N1 bytes, most significant byte first.
// A word is captured on the rising edge of wordValid only, so a level held high
// for many cycles produces a single capture.
module float_uart_tx #(
    parameter int CLKS_PER_BIT = 868,  // clock cycles per UART bit, >= 2
    parameter int FIFO_AW      = 2     // FIFO depth = 2**FIFO_AW words
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        inWord,
    input  logic               wordValid,
    output logic               txSerial,
    output logic               busy,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifoCount
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int TW    = $clog2(CLKS_PER_BIT);

    localparam logic [TW-1:0]    TMR_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // Rising-edge detection of the data-ready level
    logic wv_prev_q;
    logic push;

    // FIFO
    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ovf_q;
    logic               full;
    logic               push_ok;
    logic               drop;
    logic               pop;

    // Serialiser
    state_e         state_q, state_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [1:0]     byte_idx_q, byte_idx_d;
    logic [31:0]    word_q, word_d;
    logic           tx_q, tx_d;
    logic [7:0]     cur_byte;
    logic           bit_end;

    // Byte n of the word, counted from the most significant end
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    assign push     = wordValid & ~wv_prev_q;
    assign full     = (count_q == COUNT_FULL);
    // A push into a full FIFO still fits when the same cycle pops a word out
    assign push_ok  = push & (~full | pop);
    assign drop     = push & full & ~pop;
    assign cur_byte = byte_sel(word_q, byte_idx_q);
    assign bit_end  = (tmr_q == TMR_LAST);

    // Remember the previous wordValid level for edge detection
    // NOTE: non-blocking (<=) for every registered state so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wv_prev_q <= 1'b0;
        else     wv_prev_q <= wordValid;
    end

    // FIFO storage write port
    // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= inWord;
    end

    // Next FIFO occupancy from the push/pop pair
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (drop)    ovf_q <= 1'b1;
        end
    end

    // Serialiser next state: frame sequencing, bit timing and next line level
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        tx_d       = tx_q;
        pop        = 1'b0;

        if (state_q != S_IDLE) begin
            tmr_d = bit_end ? '0 : tmr_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                tmr_d = '0;
                if (count_q != '0) begin
                    pop        = 1'b1;
                    word_d     = mem[rd_ptr_q];
                    byte_idx_d = 2'd0;
                    state_d    = S_START;
                    tx_d       = 1'b0;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = cur_byte[0];
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = cur_byte[bit_idx_q + 3'd1];
                    end
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = S_START;
                        tx_d       = 1'b0;
                    end else if (count_q != '0) begin
                        // Back-to-back words: reload straight into a start bit
                        pop        = 1'b1;
                        word_d     = mem[rd_ptr_q];
                        byte_idx_d = 2'd0;
                        state_d    = S_START;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Serialiser registers; the line is driven straight from tx_q so it never glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            tx_q       <= tx_d;
        end
    end

    assign txSerial  = tx_q;
    assign busy      = (state_q != S_IDLE) | (count_q != '0);
    assign overflow  = ovf_q;
    assign fifoCount = count_q;

endmodule

// File: tb/tb_float_uart_tx.sv
// Directed bench for float_uart_tx with CLKS_PER_BIT=4, FIFO_AW=2.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_float_uart_tx;

    localparam int CPB = 4;
    localparam int AW  = 2;

    logic          clk;
    logic          rst;
    logic [31:0]   inWord;
    logic          wordValid;
    logic          txSerial;
    logic          busy;
    logic          overflow;
    logic [AW:0]   fifoCount;

    int n_cmp = 0;
    int n_err = 0;

    float_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .inWord    (inWord),
        .wordValid (wordValid),
        .txSerial  (txSerial),
        .busy      (busy),
        .overflow  (overflow),
        .fifoCount (fifoCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if anything hangs
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge of wordValid; returns one cycle after the push edge
    task automatic push_word(input logic [31:0] w);
        inWord    = w;
        wordValid = 1'b1;
        tick();
        wordValid = 1'b0;
        tick();
    endtask

    // UART monitor: receive one byte. in_start=1 means the current sample is
    // the first low cycle of the start bit. Returns at the middle of the stop bit.
    task automatic recv_byte(input bit in_start, output logic [7:0] b);
        int n;
        n = 0;
        b = '0;
        if (!in_start) begin
            while (txSerial !== 1'b0 && n < 400) begin
                tick();
                n++;
            end
            check("rx_start_seen", 32'(n < 400), 32'd1);
        end
        repeat (CPB / 2) tick();
        check("rx_start_mid", 32'(txSerial), 32'd0);
        for (int k = 0; k < 8; k++) begin
            repeat (CPB) tick();
            b[k] = txSerial;
        end
        repeat (CPB) tick();
        check("rx_stop_mid", 32'(txSerial), 32'd1);
    endtask

    task automatic recv_word(input bit in_start, output logic [31:0] w);
        logic [7:0] b;
        recv_byte(in_start, b);
        w[31:24] = b;
        recv_byte(1'b0, b);
        w[23:16] = b;
        recv_byte(1'b0, b);
        w[15:8] = b;
        recv_byte(1'b0, b);
        w[7:0] = b;
    endtask

    // Count low samples on the line over a window; should stay idle
    task automatic count_lows(input int cycles, output int lows);
        lows = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (txSerial !== 1'b1) lows++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] w;
    logic [7:0]  b;
    logic [7:0]  exp_b0;
    int          lows;
    int          hc;
    logic [31:0] fwords [10];

    initial begin
        fwords = '{32'h3f800000, 32'h40490fdb, 32'hbf000000, 32'h00000000, 32'h7f7fffff,
                   32'h80000000, 32'h3dcccccd, 32'hc2c80000, 32'h00000001, 32'hff800000};

        // ---------------- reset state ----------------
        rst       = 1'b1;
        wordValid = 1'b0;
        inWord    = '0;
        #3;
        check("rst_tx",    32'(txSerial),  32'd1);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_ovf",   32'(overflow),  32'd0);
        check("rst_count", 32'(fifoCount), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // ---------------- test 1/2: held level, one word, start/stop timing ----------------
        inWord    = 32'hbf83c6e0;
        wordValid = 1'b1;
        tick();                                   // push edge E
        hc = 1;
        check("t1_count_after_push", 32'(fifoCount), 32'd1);
        check("t1_busy_after_push",  32'(busy),      32'd1);
        check("t1_tx_before_start",  32'(txSerial),  32'd1);
        tick();                                   // E+1
        hc++;
        check("t1_start_first", 32'(txSerial),  32'd0);
        check("t1_count_popped", 32'(fifoCount), 32'd0);
        repeat (3) begin tick(); hc++; end        // E+4
        check("t1_start_last", 32'(txSerial), 32'd0);
        tick();                                   // E+5, first data bit
        hc++;
        exp_b0 = 8'hbf;
        check("t1_bf_bit0", 32'(txSerial), 32'(exp_b0[0]));
        for (int k = 1; k < 8; k++) begin
            repeat (CPB) begin
                tick();
                hc++;
                if (hc == 12) wordValid = 1'b0;
            end
            check($sformatf("t1_bf_bit%0d", k), 32'(txSerial), 32'(exp_b0[k]));
        end
        repeat (CPB) tick();                      // E+37
        check("t1_stop_first", 32'(txSerial), 32'd1);
        repeat (CPB - 1) tick();                  // E+40
        check("t1_stop_last", 32'(txSerial), 32'd1);
        tick();                                   // E+41
        check("t1_next_start", 32'(txSerial), 32'd0);
        check("t1_busy_between", 32'(busy),   32'd1);
        recv_byte(1'b1, b);
        check("t1_byte1", 32'(b), 32'h83);
        recv_byte(1'b0, b);
        check("t1_byte2", 32'(b), 32'hc6);
        recv_byte(1'b0, b);
        check("t1_byte3", 32'(b), 32'he0);
        repeat (CPB / 2) tick();
        check("t1_idle_busy", 32'(busy),     32'd0);
        check("t1_idle_tx",   32'(txSerial), 32'd1);
        count_lows(200, lows);
        check("t1_single_word", 32'(lows), 32'd0);

        // ---------------- test 3: overflow ----------------
        push_word(32'd1);
        fork
            begin
                for (int i = 2; i <= 6; i++) push_word(32'(i));
            end
            begin
                recv_word(1'b1, w);
            end
        join
        check("t3_word1",     w,                 32'd1);
        check("t3_ovf_set",   32'(overflow),     32'd1);
        check("t3_count_full", 32'(fifoCount),   32'd4);
        for (int i = 2; i <= 5; i++) begin
            recv_word(1'b0, w);
            check($sformatf("t3_word%0d", i), w, 32'(i));
        end
        repeat (CPB / 2) tick();
        check("t3_idle_busy", 32'(busy), 32'd0);
        count_lows(200, lows);
        check("t3_word6_dropped", 32'(lows),     32'd0);
        check("t3_ovf_sticky",    32'(overflow), 32'd1);
        rst = 1'b1;
        #1;
        check("t3_ovf_cleared", 32'(overflow), 32'd0);
        tick();
        rst = 1'b0;

        // ---------------- test 4: push and pop on the same edge while full ----------------
        push_word(32'h11111111);                  // push at E, shifter
        push_word(32'h22222222);
        push_word(32'h33333333);
        push_word(32'h44444444);
        push_word(32'h55555555);                  // returns at E+9
        check("t4_count_full", 32'(fifoCount), 32'd4);
        repeat (151) tick();                      // E+160: last stop cycle
        check("t4_last_stop", 32'(txSerial), 32'd1);
        inWord    = 32'h66666666;
        wordValid = 1'b1;
        tick();                                   // E+161: pop and push together
        wordValid = 1'b0;
        check("t4_count_same", 32'(fifoCount), 32'd4);
        check("t4_no_ovf",     32'(overflow),  32'd0);
        check("t4_no_gap",     32'(txSerial),  32'd0);
        recv_word(1'b1, w);
        check("t4_word2", w, 32'h22222222);
        for (int i = 3; i <= 6; i++) begin
            recv_word(1'b0, w);
            check($sformatf("t4_word%0d", i), w, {8{4'(i)}});
        end
        check("t4_no_ovf_end", 32'(overflow), 32'd0);
        repeat (CPB / 2) tick();
        check("t4_idle_busy", 32'(busy), 32'd0);

        // ---------------- test 5: reset mid-frame ----------------
        push_word(32'h11223344);                  // push at E, returns E+1
        push_word(32'haabbccdd);                  // returns E+3
        check("t5_count_one", 32'(fifoCount), 32'd1);
        repeat (97) tick();                       // E+100: byte 2 data
        rst = 1'b1;
        #1;
        check("t5_rst_tx",    32'(txSerial),  32'd1);
        check("t5_rst_busy",  32'(busy),      32'd0);
        check("t5_rst_count", 32'(fifoCount), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        count_lows(20, lows);
        check("t5_quiet_after_rst", 32'(lows), 32'd0);
        push_word(32'h3f2d6547);
        recv_word(1'b1, w);
        check("t5_clean_word", w, 32'h3f2d6547);
        repeat (CPB / 2) tick();
        check("t5_idle_busy", 32'(busy), 32'd0);

        // ---------------- test 6: ten spaced words ----------------
        for (int i = 0; i < 10; i++) begin
            push_word(fwords[i]);
            recv_word(1'b1, w);
            check($sformatf("t6_word%0d", i), w, fwords[i]);
            check($sformatf("t6_ovf%0d", i), 32'(overflow), 32'd0);
            repeat (840) tick();
        end
        check("t6_idle_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
